// File: rtl/screen_ctrl.sv
// Screen sequencer: opening picture, gameplay, win/lose picture with a minimum hold time,
// and the pixel mux that feeds the VGA adapter from either the picture drawer or the game.
module screen_ctrl #(
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned PIC_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_key,
    input  logic       game_won,
    input  logic       game_lost,
    input  logic       pic_done,
    input  logic [9:0] pic_x,
    input  logic [9:0] pic_y,
    input  logic [1:0] pic_colour,
    input  logic       pic_plot,
    input  logic [9:0] game_x,
    input  logic [9:0] game_y,
    input  logic [2:0] game_colour,
    input  logic       game_plot,
    output logic       pic_go,
    output logic [2:0] selection,
    output logic       game_enable,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        OPEN_GO,
        OPEN_WAIT,
        OPEN_IDLE,
        PLAY,
        END_GO,
        END_WAIT,
        END_HOLD
    } state_t;

    localparam logic [31:0] HOLD_MAX = 32'(HOLD_CYCLES);
    localparam logic [16:0] WAIT_MAX = 17'(PIC_TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [16:0] wait_q, wait_d;
    logic [31:0] hold_q, hold_d;
    logic        err_q, err_d;
    logic        key_prev_q;
    logic        pic_go_q, pic_go_d;
    logic        game_en_q, game_en_d;

    logic        key_edge;
    logic [16:0] wait_inc;
    logic        pic_ready;

    logic [9:0]  src_x, src_y;
    logic [2:0]  src_colour;
    logic        src_plot;
    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [2:0]  vga_colour_q;
    logic        vga_plot_q;

    assign key_edge  = start_key & ~key_prev_q;
    assign wait_inc  = wait_q + 17'd1;
    assign pic_ready = pic_done | (wait_inc == WAIT_MAX);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        err_d   = err_q;
        unique case (state_q)
            OPEN_GO: begin
                state_d = OPEN_WAIT;
                wait_d  = '0;
                sel_d   = 3'b001;
            end
            OPEN_WAIT, END_WAIT: begin
                wait_d = wait_inc;
                if (pic_ready) begin
                    state_d = (state_q == OPEN_WAIT) ? OPEN_IDLE : END_HOLD;
                    hold_d  = '0;
                    if (!pic_done) err_d = 1'b1;
                end
            end
            OPEN_IDLE: begin
                if (key_edge) begin
                    state_d = PLAY;
                    sel_d   = '0;
                end
            end
            PLAY: begin
                if (game_lost) begin
                    state_d = END_GO;
                    sel_d   = 3'b100;
                end else if (game_won) begin
                    state_d = END_GO;
                    sel_d   = 3'b010;
                end
            end
            END_GO: begin
                state_d = END_WAIT;
                wait_d  = '0;
            end
            END_HOLD: begin
                if (hold_q != HOLD_MAX) hold_d = hold_q + 32'd1;
                // Edges before the hold expires are dropped, not latched for later.
                if (key_edge && hold_q == HOLD_MAX) begin
                    state_d = OPEN_GO;
                    sel_d   = 3'b001;
                end
            end
            default: state_d = OPEN_GO;
        endcase
    end

    // Pulse is registered off the GO state, so it appears in the first cycle after it.
    assign pic_go_d  = (state_q == OPEN_GO) || (state_q == END_GO);
    assign game_en_d = (state_d == PLAY);

    always_comb begin
        if (state_q == PLAY) begin
            src_x      = game_x;
            src_y      = game_y;
            src_colour = game_colour;
            src_plot   = game_plot;
        end else begin
            src_x    = pic_x;
            src_y    = pic_y;
            src_plot = pic_plot;
            unique case (pic_colour)
                2'b00:   src_colour = 3'b000;
                2'b01:   src_colour = 3'b111;
                2'b10:   src_colour = 3'b100;
                default: src_colour = 3'b010;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= OPEN_GO;
            sel_q        <= 3'b001;
            wait_q       <= '0;
            hold_q       <= '0;
            err_q        <= 1'b0;
            key_prev_q   <= 1'b1;
            pic_go_q     <= 1'b0;
            game_en_q    <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            wait_q       <= wait_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
            key_prev_q   <= start_key;
            pic_go_q     <= pic_go_d;
            game_en_q    <= game_en_d;
            vga_x_q      <= src_x[7:0];
            vga_y_q      <= src_y[6:0];
            vga_colour_q <= src_colour;
            vga_plot_q   <= src_plot && (src_x < 10'd160) && (src_y < 10'd120);
        end
    end

    assign pic_go      = pic_go_q;
    assign selection   = sel_q;
    assign game_enable = game_en_q;
    assign timeout_err = err_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;

endmodule

// File: doc/screen_ctrl.md
SCREEN_CTRL -- requirements
Module: screen_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000: minimum cycles an end screen is shown before a key press is accepted.
REQ-002 Parameter PIC_TIMEOUT, default 65535: maximum cycles spent waiting for pic_done.
REQ-003 clk  in  1  system clock; all logic on the rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 start_key  in  1  player start/continue request, active-high level.
REQ-006 game_won, game_lost  in  1 each  level flags from the game core.
REQ-007 pic_done  in  1  single-cycle pulse from the picture drawer when its image is complete.
REQ-008 pic_x, pic_y  in  10 each; pic_colour  in  2; pic_plot  in  1  picture-drawer pixel stream.
REQ-009 game_x, game_y  in  10 each; game_colour  in  3; game_plot  in  1  game pixel stream.
REQ-010 pic_go  out  1  single-cycle start pulse to the picture drawer.
REQ-011 selection  out  3  one-hot image select: 001 opening, 010 win, 100 lose, 000 none.
REQ-012 game_enable  out  1  high only while the game is running.
REQ-013 vga_x  out  8; vga_y  out  7; vga_colour  out  3; vga_plot  out  1  registered pixel write to the VGA adapter.
REQ-014 timeout_err  out  1  sticky flag, set when a picture wait times out.

Function
REQ-015 The FSM shall have these states: OPEN_GO, OPEN_WAIT, OPEN_IDLE, PLAY, END_GO, END_WAIT, END_HOLD.
REQ-016 OPEN_GO shall assert pic_go for exactly one cycle with selection=001, then enter OPEN_WAIT.
REQ-017 OPEN_WAIT shall enter OPEN_IDLE on pic_done.
REQ-018 OPEN_IDLE shall enter PLAY on a start_key rising edge, detected against a register holding the previous start_key value.
REQ-019 PLAY shall hold game_enable=1 and selection=000.
REQ-020 In PLAY, game_lost=1 shall enter END_GO with selection=100; otherwise game_won=1 shall enter END_GO with selection=010; lost has priority when both are high in the same cycle.
REQ-021 END_GO shall pulse pic_go for one cycle, keep selection, then enter END_WAIT.
REQ-022 END_WAIT shall enter END_HOLD on pic_done and clear the 32-bit hold counter.
REQ-023 END_HOLD shall increment the hold counter each cycle, saturating at HOLD_CYCLES.
REQ-024 END_HOLD shall accept a start_key rising edge only when the counter equals HOLD_CYCLES, then enter OPEN_GO; earlier edges shall be ignored and not remembered.
REQ-025 The 17-bit wait counter shall clear on entry to OPEN_WAIT/END_WAIT and increment each waiting cycle.
REQ-026 If the wait counter reaches PIC_TIMEOUT without pic_done, the FSM shall proceed as if pic_done arrived and set timeout_err, which only reset clears.
REQ-027 pic_done outside OPEN_WAIT/END_WAIT shall be ignored.
REQ-028 Pixel routing: in PLAY the source shall be the game stream; in every other state the picture stream; the unselected stream shall be discarded.
REQ-029 Picture colour shall map 2-bit to 3-bit: 00->000, 01->111, 10->100, 11->010.
REQ-030 Clipping: a pixel with x>=160 or y>=120 shall produce vga_plot=0; otherwise vga_x=x[7:0] and vga_y=y[6:0].
REQ-031 The VGA outputs shall be registered with one cycle of latency from the input stream; vga_plot shall equal the source plot AND the in-range condition.
REQ-032 game_enable shall drop in the same cycle the FSM leaves PLAY.

Reset
REQ-033 While resetn=0 at a clock edge, the block shall enter OPEN_GO and clear vga_*, pic_go, game_enable, timeout_err and both counters; selection shall be 001.
REQ-034 Reset mid-operation in any state, including during a picture wait, shall abandon that operation; the first cycle after release shall pulse pic_go with selection=001.
REQ-035 The start_key edge register shall reset to 1, so a key held through reset does not count as an edge.

Verification
REQ-036 Release reset -> pic_go high for 1 cycle with selection=001; pulse pic_done -> OPEN_IDLE; start_key 0->1 -> game_enable=1 on the next cycle.
REQ-037 In PLAY, set game_won=1 and game_lost=1 in the same cycle -> selection=100, one pic_go pulse, game_enable=0.
REQ-038 HOLD_CYCLES=10: key edge at hold count 5 -> ignored; key edge after count 10 -> pic_go pulse with selection=001.
REQ-039 PIC_TIMEOUT=20, pic_done withheld -> after 20 wait cycles the FSM advances and timeout_err=1 until reset.
REQ-040 Picture pixel (159,119,colour 10,plot 1) -> next cycle vga=(159,119,100,plot 1); pixel (160,5,plot 1) -> vga_plot=0.
REQ-041 Game pixel with game_plot=1 sent while in OPEN_IDLE -> vga_plot=0.
